// File: rtl/window_pkg.sv
// Shared types and sizing helpers for the window accumulator and its output slice.
package window_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_WINDOW = 4;
   localparam int DEF_SEQ_W  = 8;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   // Sum width that cannot overflow for WINDOW samples of DATA_W bits.
   function automatic int sum_width(input int data_w, input int window);
      return data_w + $clog2(window);
   endfunction

endpackage

// File: rtl/result_holding_reg.sv
// Single-entry valid/ready register slice; reloads in the consume cycle so
// back-to-back results flow without a bubble.
module result_holding_reg
   import window_pkg::*;
#(
   parameter int PAYLOAD_W = 19
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [PAYLOAD_W-1:0] data_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [PAYLOAD_W-1:0] data_o
);

   buf_state_e           state_q, state_d;
   logic [PAYLOAD_W-1:0] data_q, data_d;

   // Buffer state and held payload registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         data_q  <= {PAYLOAD_W{1'b0}};
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Next-state: load on completion, drain on consume, reload when both coincide.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         BUF_EMPTY: begin
            if (load_i) begin
               state_d = BUF_FULL;
               data_d  = data_i;
            end else begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (ready_i && load_i) begin
               state_d = BUF_FULL;
               data_d  = data_i;
            end else if (ready_i) begin
               state_d = BUF_EMPTY;
            end else begin
               state_d = BUF_FULL;
            end
         end
         default: begin
            state_d = BUF_EMPTY;
            data_d  = {PAYLOAD_W{1'b0}};
         end
      endcase
   end

   assign valid_o = (state_q == BUF_FULL);
   assign data_o  = data_q;

endmodule

// File: rtl/window_accumulator.sv
// Sums non-overlapping windows of WINDOW accepted samples and hands each sum,
// an all-zero flag and a sequence number to a single-entry output slice.
module window_accumulator
   import window_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int WINDOW = DEF_WINDOW,
   parameter int SEQ_W  = DEF_SEQ_W
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [DATA_W-1:0]                     in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [sum_width(DATA_W, WINDOW)-1:0]  out_sum,
   output logic                                  out_zero,
   output logic [SEQ_W-1:0]                      out_seq,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int                SUM_W    = sum_width(DATA_W, WINDOW);
   localparam int                CNT_W    = $clog2(WINDOW);
   localparam int                PAY_W    = SUM_W + 1 + SEQ_W;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW - 1);

   logic [SUM_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             all_zero_q, all_zero_d;
   logic [SEQ_W-1:0] seq_q, seq_d;

   logic             last_slot_s, accept_s, complete_s, win_zero_s;
   logic [SUM_W-1:0] win_sum_s;
   logic [PAY_W-1:0] payload_s, held_s;

   // Accumulator, slot counter, zero tracker and window sequence registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q      <= {SUM_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         all_zero_q <= 1'b1;
         seq_q      <= {SEQ_W{1'b0}};
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         all_zero_q <= all_zero_d;
         seq_q      <= seq_d;
      end
   end

   // Only the last slot stalls, and only while a result is pending and not leaving.
   always_comb begin
      last_slot_s = (cnt_q == LAST_CNT);
      in_ready    = !(out_valid && !out_ready && last_slot_s);
      accept_s    = in_valid && in_ready;
      complete_s  = accept_s && last_slot_s;
      win_sum_s   = acc_q + SUM_W'(in_data);
      win_zero_s  = all_zero_q && (in_data == {DATA_W{1'b0}});
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      all_zero_d  = all_zero_q;
      seq_d       = seq_q;
      if (complete_s) begin
         acc_d      = {SUM_W{1'b0}};
         cnt_d      = {CNT_W{1'b0}};
         all_zero_d = 1'b1;
         seq_d      = seq_q + SEQ_W'(1);
      end else if (accept_s) begin
         acc_d      = win_sum_s;
         cnt_d      = cnt_q + CNT_W'(1);
         all_zero_d = win_zero_s;
      end else begin
         acc_d      = acc_q;
      end
   end

   assign payload_s = {win_sum_s, win_zero_s, seq_q};

   result_holding_reg #(
      .PAYLOAD_W (PAY_W)
   ) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (complete_s),
      .data_i  (payload_s),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (held_s)
   );

   assign {out_sum, out_zero, out_seq} = held_s;

endmodule

// File: tb/tb_window_accumulator.sv
// Directed bench: expected results queued at stimulus time, popped and compared
// by a monitor whenever the DUT hands a result over.
module tb_window_accumulator;

   typedef struct packed {
      logic [9:0] sum;
      logic       zero;
      logic [7:0] seq;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] out_sum;
   logic       out_zero;
   logic [7:0] out_seq;
   logic       out_valid;
   logic       out_ready;

   res_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   seq_exp = 0;

   window_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_zero  (out_zero),
      .out_seq   (out_seq),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: one comparison per consumed result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         res_t e;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL result: unexpected output sum=%0d zero=%0d seq=%0d, none expected",
                     out_sum, out_zero, out_seq);
         end else begin
            e = exp_q.pop_front();
            if ({out_sum, out_zero, out_seq} !== e) begin
               n_miss++;
               $display("FAIL result: got sum=%0d zero=%0d seq=%0d, want sum=%0d zero=%0d seq=%0d",
                        out_sum, out_zero, out_seq, e.sum, e.zero, e.seq);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic expect_res(input int sum, input logic zero);
      res_t r;
      r.sum  = 10'(sum);
      r.zero = zero;
      r.seq  = 8'(seq_exp);
      exp_q.push_back(r);
      seq_exp++;
   endtask

   task automatic send(input logic [7:0] d);
      logic took;
      int   guard;
      took     = 1'b0;
      guard    = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!took && guard < 50) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!took) begin
         n_vec++;
         n_miss++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want 1", guard);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 8'hAA;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      seq_exp = 0;
   endtask

   initial begin
      int gap;
      rst_n     = 1'b0;
      in_data   = 8'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      do_reset();
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_sum", int'(out_sum), 0);
      chk("reset_seq", int'(out_seq), 0);
      chk("reset_in_ready", int'(in_ready), 1);

      // Doubling stream with single-cycle valid pulse
      expect_res(15, 1'b0);
      send(8'd1); send(8'd2); send(8'd4);
      chk("pre_last_valid", int'(out_valid), 0);
      send(8'd8);
      chk("latency_valid", int'(out_valid), 1);
      idle();
      chk("one_cycle_valid", int'(out_valid), 0);

      // Producer wrap: nonzero then all-zero window
      expect_res(128, 1'b0);
      send(8'd128); send(8'd0); send(8'd0); send(8'd0);
      expect_res(0, 1'b1);
      for (int i = 0; i < 4; i++) send(8'd0);

      // Maximum value
      expect_res(1020, 1'b0);
      for (int i = 0; i < 4; i++) send(8'd255);
      wait_drain();

      // Backpressure: second window's last slot stalls until consume
      do_reset();
      out_ready = 1'b0;
      expect_res(4, 1'b0);
      expect_res(4, 1'b0);
      for (int i = 0; i < 7; i++) send(8'd1);
      in_data  = 8'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", int'(in_ready), 0);
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_sum", int'(out_sum), 4);
         chk("stall_seq", int'(out_seq), 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("no_bubble_valid", int'(out_valid), 1);
      chk("no_bubble_seq", int'(out_seq), 1);
      wait_drain();

      // Reset mid-window, with an accept offered in the reset cycle
      send(8'd10); send(8'd20);
      rst_n    = 1'b0;
      in_data  = 8'd5;
      in_valid = 1'b1;
      @(negedge clk);
      chk("rst_cycle_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("rst_after_valid", int'(out_valid), 0);
      chk("rst_after_seq", int'(out_seq), 0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      seq_exp  = 0;
      expect_res(4, 1'b0);
      for (int i = 0; i < 4; i++) send(8'd1);
      wait_drain();

      // Sequence wrap with periodic input gaps
      do_reset();
      gap = 0;
      for (int w = 0; w < 257; w++) begin
         expect_res(4, 1'b0);
         for (int k = 0; k < 4; k++) begin
            gap++;
            if (gap % 3 == 0) idle();
            send(8'd1);
         end
      end
      chk("wrap_last_seq", int'(out_seq), 0);
      chk("wrap_last_sum", int'(out_sum), 4);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
- Downstream consumer of the 8-bit doubling-register stream.
- Sums each non-overlapping window of WINDOW accepted samples.
- Presents each window sum, a window-all-zero flag and a window sequence number on a valid/ready output port.
- The output is single-entry buffered, so accumulation of the next window continues while a result waits for the consumer.

Parameters:
- DATA_W, 8, sample width; matches the 8-bit producer output.
- WINDOW, 4, samples per window; power of two, at least 2.
- SUM_W, DATA_W+$clog2(WINDOW), sum width (10 by default); localparam, not overridable.
- SEQ_W, 8, window sequence-number width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  sample from the producer.
- in_valid  in  1  sample present this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- out_sum  out  SUM_W  completed window sum.
- out_zero  out  1  every sample in the window was 0.
- out_seq  out  SEQ_W  index of this window; wraps modulo 2^SEQ_W.
- out_valid  out  1  result held on out_*.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-low on rst_n, sampled on the rising clk edge; there are no asynchronous paths.
  - While rst_n=0 at an edge, all of these clear to 0: acc, cnt, all_zero (set to 1 instead), out_sum, out_zero, out_valid, out_seq, seq counter.
  - An in-progress window and any pending result are discarded at reset.
- Handshakes:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - in_data is ignored when in_valid=0.
  - Once raised, out_valid and out_* stay stable until consumed.
- Accumulator path:
  - State: acc[SUM_W], cnt[$clog2(WINDOW)], all_zero flag.
  - On accept with cnt<WINDOW-1: acc<=acc+in_data (zero-extended, unsigned), cnt<=cnt+1, all_zero<=all_zero&&(in_data==0).
  - On accept with cnt==WINDOW-1 (the last slot): the window completes.
    - out_sum<=acc+in_data.
    - out_zero<=all_zero&&(in_data==0).
    - out_seq<=seq, then seq<=seq+1.
    - out_valid<=1.
    - acc<=0, cnt<=0, all_zero<=1.
- Arithmetic: SUM_W guarantees no overflow (max 255*4=1020 < 1024), so there is no saturation logic.
- Latency: out_valid rises on the clock edge that accepts the last sample, so it is visible the cycle after that sample is presented.
- Output buffer FSM, two states:
  - EMPTY (out_valid=0): moves to FULL when a window completes.
  - FULL (out_valid=1):
    - Consume with no completion: go to EMPTY.
    - Consume and completion in the same cycle: stay FULL and load the new result, with no bubble.
    - Completion with no consume: impossible, because of the in_ready rule below.
- Backpressure:
  - in_ready = !(out_valid && !out_ready && cnt==WINDOW-1).
  - Only the last slot of a window is stalled, and only while a result is pending and not being consumed.
  - in_ready therefore depends combinationally on out_ready; this is the only comb path from input to output.
- Boundaries:
  - Gaps in in_valid do not reset cnt.
  - seq wraps from 255 to 0.
  - A stall of arbitrary length holds acc, cnt and the output unchanged.
  - Reset asserted in the same cycle as an accept or consume: reset wins.

Decomposition:
- Shared package window_pkg:
  - Output-buffer state enum {BUF_EMPTY, BUF_FULL}.
  - Default DATA_W/WINDOW constants.
  - The SUM_W computation function.
- One natural sub-module, result_holding_reg: a single-entry valid/ready register slice holding {sum, zero, seq}, containing the buffer FSM.
- The top level holds the accumulator, counter and in_ready logic.

Test Plan:
- Doubling stream: in_data 1,2,4,8 with in_valid=1 and out_ready=1 → out_sum=15, out_zero=0, out_seq=0; out_valid high for exactly one cycle, the cycle after sample 8.
- Producer wrap: 128,0,0,0 then 0,0,0,0 → first result sum=128 with zero=0; second result sum=0 with zero=1, seq=1.
- Maximum value: 255 ×4 → out_sum=1020, no wrap.
- Backpressure: out_ready=0, eight consecutive valid samples of 1 → first result sum=4 held stable.
  - The 8th sample sees in_ready=0 until out_ready=1.
  - In that cycle the 8th sample is accepted and the result is replaced by sum=4, seq=1 with no bubble.
- Reset mid-window: accept 10, 20, then rst_n=0 for one cycle, then 1,1,1,1 → a single result sum=4, seq=0; out_valid=0 throughout the reset cycle.
- Sequence wrap and input gaps: 257 windows of value 1, with in_valid deasserted every third cycle → the 257th result has out_seq=0 and sum=4.
